// File: rtl/wake_ctrl_if.sv
// Word-detector handoff and wake/irq result bundle for wake_ctrl.
// master drives detections and irq clear; slave returns wake, irq, busy, count.
interface wake_ctrl_if #(
    parameter int CNT_BW = 16
);
    logic              wrd_wake;
    logic              wrd_wake_valid;
    logic              irq_clr;
    logic              wake;
    logic              irq;
    logic              busy;
    logic [CNT_BW-1:0] wake_cnt;

    modport master (
        output wrd_wake, wrd_wake_valid, irq_clr,
        input  wake, irq, busy, wake_cnt
    );

    modport slave (
        input  wrd_wake, wrd_wake_valid, irq_clr,
        output wake, irq, busy, wake_cnt
    );
endinterface

// File: rtl/wake_ctrl.sv
// Wake pulse / refractory cooldown / sticky irq stage after the word detector.
// Optional accepted-wake counter: define WAKE_CTRL_CNT_EN.
module wake_ctrl #(
    parameter int HOLD_CYCLES     = 16,
    parameter int COOLDOWN_CYCLES = 1024,
    parameter int CNT_BW          = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            ctl_pipeline_en_i,
    wake_ctrl_if.slave      bus
);
    localparam int MAXC = (HOLD_CYCLES > COOLDOWN_CYCLES) ?
                          HOLD_CYCLES : COOLDOWN_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LD = (COOLDOWN_CYCLES > 0) ?
                                        TW'(COOLDOWN_CYCLES - 1) : '0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] COOL = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          wake_q, wake_d;
    logic          irq_q, irq_d;
    logic          ev;
    logic          accept;

    assign ev = bus.wrd_wake_valid & bus.wrd_wake & ctl_pipeline_en_i;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        wake_d  = wake_q;
        accept  = 1'b0;
        if (!ctl_pipeline_en_i) begin
            state_d = IDLE;
            timer_d = '0;
            wake_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ev) begin
                        state_d = HOLD;
                        timer_d = HOLD_LD;
                        wake_d  = 1'b1;
                        accept  = 1'b1;
                    end
                end
                HOLD: begin
                    if (timer_q == '0) begin
                        wake_d = 1'b0;
                        if (COOLDOWN_CYCLES > 0) begin
                            state_d = COOL;
                            timer_d = COOL_LD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                COOL: begin
                    if (timer_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    wake_d  = 1'b0;
                end
            endcase
        end
        // a new wake beats a simultaneous firmware clear
        irq_d = accept | (irq_q & ~bus.irq_clr);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            wake_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            wake_q  <= wake_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.wake = wake_q;
    assign bus.irq  = irq_q;
    assign bus.busy = (state_q != IDLE);

`ifdef WAKE_CTRL_CNT_EN
    logic [CNT_BW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.wake_cnt = cnt_q;
`else
    assign bus.wake_cnt = '0;
`endif
endmodule
